// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and
// the one-hot {gt, eq, lt} result encodings.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_chunk_cmp.sv
// Combinational CHUNK-bit unsigned compare; invert_msb flips the top bit of
// both operands so the sign chunk of a two's-complement value orders correctly.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] w_mask;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

  always_comb begin
    w_mask            = '0;
    w_mask[CHUNK-1]   = invert_msb;
    w_a               = a ^ w_mask;
    w_b               = b ^ w_mask;
    gt                = (w_a > w_b);
    eq                = (w_a == w_b);
    lt                = (w_a < w_b);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices from the MSB end
// and stops at the first slice that differs.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          signed_mode,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          a_grt_b,
  output logic                          a_eq_b,
  output logic                          a_less_b,
  output logic [$clog2(WIDTH/CHUNK):0]  res_cycles,
  output logic [1:0]                    o_dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Handshakes: a request transfers on a rising edge with start_valid &&
  // start_ready; a result transfers on a rising edge with res_valid &&
  // res_ready. Both ready/valid outputs are pure state decodes, so neither
  // handshake has a combinational path through the block.

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_res;
  logic [CW-1:0]    r_res_cycles;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic             w_invert;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;

  assign w_a_chunk = r_a[CHUNK*r_idx +: CHUNK];
  assign w_b_chunk = r_b[CHUNK*r_idx +: CHUNK];
  assign w_invert  = r_signed && (r_idx == IW'(NCHUNK-1));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a          (w_a_chunk),
    .b          (w_b_chunk),
    .invert_msb (w_invert),
    .gt         (w_gt),
    .eq         (w_eq),
    .lt         (w_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start_valid)                  w_next_state = CMP;
      CMP:  if (!w_eq || r_idx == '0)         w_next_state = DONE;
      DONE: if (res_ready)                    w_next_state = IDLE;
      default:                                w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_signed     <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_res        <= '0;
      r_res_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_idx    <= IW'(NCHUNK-1);
            r_cnt    <= '0;
          end
        end
        CMP: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_gt) begin
            r_res        <= RES_GT;
            r_res_cycles <= r_cnt + 1'b1;
          end else if (w_lt) begin
            r_res        <= RES_LT;
            r_res_cycles <= r_cnt + 1'b1;
          end else if (r_idx == '0) begin
            r_res        <= RES_EQ;
            r_res_cycles <= CW'(NCHUNK);
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE);
  assign res_valid   = (r_state == DONE);
  assign a_grt_b     = r_res[2];
  assign a_eq_b      = r_res[1];
  assign a_less_b    = r_res[0];
  assign res_cycles  = r_res_cycles;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4) with
// hand-computed expected flags, chunk counts and latencies.
module tb_seq_magnitude_comparator;
  import cmp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        res_valid;
  logic        res_ready;
  logic        a_grt_b;
  logic        a_eq_b;
  logic        a_less_b;
  logic [2:0]  res_cycles;
  logic [1:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .a_grt_b     (a_grt_b),
    .a_eq_b      (a_eq_b),
    .a_less_b    (a_less_b),
    .res_cycles  (res_cycles),
    .o_dbg_state (o_dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for start_ready, offers one request, then scrambles the inputs
  // and counts cycles until res_valid is seen.
  task automatic send_req(input logic [15:0] ta, input logic [15:0] tb_v, input logic s,
                          input logic [2:0] ef, input logic [2:0] ec, output int lat);
    int w;
    exp_q.push_back({ef, ec});
    w = 0;
    while (!start_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) check_val("accept_timeout", 32'(w), 32'd0);
    a = ta; b = tb_v; signed_mode = s; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = ~ta; b = tb_v ^ 16'h5a5a; signed_mode = ~s;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat);
    logic [5:0] e;
    e = exp_q.pop_front();
    check_val({tag, "_valid"},   32'(res_valid), 32'd1);
    check_val({tag, "_flags"},   32'({a_grt_b, a_eq_b, a_less_b}), 32'(e[5:3]));
    check_val({tag, "_cycles"},  32'(res_cycles), 32'(e[2:0]));
    check_val({tag, "_latency"}, 32'(lat), 32'(e[2:0]));
  endtask

  // Result is consumed on the next edge (res_ready=1); block is back in IDLE.
  task automatic finish_req(input string tag);
    @(posedge clk); #1;
    check_val({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check_val({tag, "_ready_back"}, 32'(start_ready), 32'd1);
  endtask

  task automatic run_case(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic s, input logic [2:0] ef, input logic [2:0] ec);
    int lat;
    send_req(ta, tb_v, s, ef, ec, lat);
    check_result(tag, lat);
    finish_req(tag);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; res_ready = 1'b1;
    #3;
    check_val("rst_start_ready", 32'(start_ready), 32'd1);
    check_val("rst_res_valid",   32'(res_valid),   32'd0);
    check_val("rst_flags",       32'({a_grt_b, a_eq_b, a_less_b}), 32'd0);
    check_val("rst_cycles",      32'(res_cycles),  32'd0);
    check_val("rst_state",       32'(o_dbg_state), 32'(IDLE));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_case("gt_top",      16'h1234, 16'h0234, 1'b0, F_GT, 3'd1);
    run_case("eq_beef",     16'hBEEF, 16'hBEEF, 1'b0, F_EQ, 3'd4);
    run_case("signed_neg",  16'h8000, 16'h0001, 1'b1, F_LT, 3'd1);
    run_case("unsigned_hi", 16'h8000, 16'h0001, 1'b0, F_GT, 3'd1);
    run_case("lt_last",     16'h1235, 16'h1236, 1'b0, F_LT, 3'd4);
    run_case("signed_m1",   16'hFFFF, 16'h0000, 1'b1, F_LT, 3'd1);
    run_case("signed_max",  16'h7FFF, 16'h8000, 1'b1, F_GT, 3'd1);
    run_case("signed_eq",   16'h8000, 16'h8000, 1'b1, F_EQ, 3'd4);
    run_case("lt_chunk1",   16'h00A0, 16'h00B0, 1'b0, F_LT, 3'd3);

    // backpressure: result must hold while res_ready is low
    res_ready = 1'b0;
    send_req(16'h3C00, 16'h3B00, 1'b0, F_GT, 3'd2, lat);
    check_result("bp", lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 16'hFFFF; b = 16'h0000; start_valid = 1'b1;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      check_val("bp_hold_valid",  32'(res_valid), 32'd1);
      check_val("bp_hold_flags",  32'({a_grt_b, a_eq_b, a_less_b}), 32'(F_GT));
      check_val("bp_hold_cycles", 32'(res_cycles), 32'd2);
      check_val("bp_hold_sready", 32'(start_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_valid",  32'(res_valid),   32'd0);
    check_val("bp_release_sready", 32'(start_ready), 32'd1);
    check_val("bp_release_state",  32'(o_dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    check_val("bp_no_queue_state", 32'(o_dbg_state), 32'(IDLE));

    // reset during CMP of an all-equal compare
    a = 16'hBEEF; b = 16'hBEEF; signed_mode = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    check_val("mid_state_cmp", 32'(o_dbg_state), 32'(CMP));
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sready", 32'(start_ready), 32'd1);
    check_val("mid_rst_valid",  32'(res_valid),   32'd0);
    check_val("mid_rst_flags",  32'({a_grt_b, a_eq_b, a_less_b}), 32'd0);
    check_val("mid_rst_cycles", 32'(res_cycles),  32'd0);
    check_val("mid_rst_state",  32'(o_dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_case("post_rst", 16'h0001, 16'h0000, 1'b0, F_GT, 3'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Multi-cycle, parametrised magnitude comparator for WIDTH-bit operands.
- Compares CHUNK bits per cycle, starting at the MSB end, and stops as soon as a chunk differs.
- Supports unsigned and two's-complement modes.
- Uses valid/ready handshakes on both input and result. It is the sequential successor to the 4-bit combinational comparator and is intended for wide datapaths where a single-cycle compare would limit timing.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle. Must be ≥1.
- NCHUNK, WIDTH/CHUNK, derived localparam. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  request valid
- start_ready  output  1  block can accept a request
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
- res_valid  output  1  result valid
- res_ready  input  1  result consumer ready
- a_grt_b  output  1  A > B
- a_eq_b  output  1  A == B
- a_less_b  output  1  A < B
- res_cycles  output  $clog2(NCHUNK)+1  number of chunks examined for this result

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; start_ready=1; res_valid=0; a_grt_b=a_eq_b=a_less_b=0; res_cycles=0; internal index and operand registers cleared.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - start_ready=1.
  - On the edge where start_valid&&start_ready: latch a, b and signed_mode; set idx=NCHUNK-1 and cnt=0; go to CMP.
- CMP:
  - start_ready=0.
  - Each cycle, compare chunk idx of the latched operands and increment cnt.
  - For the top chunk only, when signed_mode=1, invert the sign bit of both operands before the unsigned chunk compare.
  - If the chunks differ: register a_grt_b/a_less_b accordingly, set res_cycles=cnt+1, go to DONE.
  - If the chunks are equal and idx==0: set a_eq_b=1 and res_cycles=NCHUNK, go to DONE.
  - Otherwise decrement idx and stay in CMP.
- DONE:
  - res_valid=1.
  - Flags and res_cycles are held stable while res_ready=0.
  - On res_valid&&res_ready: go to IDLE and deassert res_valid. Flags hold their last values; they are meaningful only while res_valid=1.
- Latency: res_valid goes high k cycles after the accept edge, where k is the number of chunks examined (1..NCHUNK).
- Throughput: minimum k+2 cycles per request.
- Flag encoding: exactly one flag is high whenever res_valid=1.
- Input stability: a, b and signed_mode are sampled only at the accept edge. Changes during CMP or DONE are ignored.
- start_valid outside IDLE is ignored; no queuing.
- start_ready is registered and depends only on state. There is no combinational path from res_ready to start_ready, so there is a one-cycle bubble after the result handshake.
- Reset mid-operation: aborts immediately. All outputs return to reset values asynchronously. The first accept is possible on the first edge after rst_n deasserts.
- NCHUNK=1 degenerates to a 1-cycle compare; the FSM is unchanged.

Decomposition:
- Package cmp_pkg:
  - state enum typedef (IDLE, CMP, DONE);
  - result encoding localparams RES_GT/RES_EQ/RES_LT.
- Sub-module chunk_cmp: combinational CHUNK-bit compare with an invert_msb input, producing gt/eq/lt. One instance, muxed by idx.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4, res_ready=1 unless stated.
- a=0x1234, b=0x0234, unsigned → a_grt_b=1, res_cycles=1, res_valid high 1 cycle after accept.
- a=0xBEEF, b=0xBEEF → a_eq_b=1, res_cycles=4, res_valid 4 cycles after accept.
- a=0x8000, b=0x0001: signed_mode=1 → a_less_b=1; signed_mode=0 → a_grt_b=1. Both give res_cycles=1.
- a=0x1235, b=0x1236 → a_less_b=1, res_cycles=4. Changing a/b during CMP does not alter the result.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → flags, res_cycles and res_valid stable; start_ready=0; a pulsed start_valid is not accepted. After release, start_ready=1 one cycle later.
- Assert rst_n=0 during CMP of a 0xBEEF/0xBEEF compare → outputs immediately at reset values. After release, a new request (0x0001 vs 0x0000) returns a_grt_b=1 with res_cycles=4.
